// File: rtl/bg_cfg_ctrl.sv
// Background draw-stage configuration controller: round-robin update arbitration,
// a shadow register committed on the vblnk rising edge, a timed hit-flash override and a frame counter.
module bg_cfg_ctrl #(
  parameter logic [11:0] DEFAULT_COLOR  = 12'h888,
  parameter int          BORDER_W       = 6,
  parameter int unsigned DEFAULT_BORDER = 4,
  parameter int          FLASH_W        = 6,
  parameter int          FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_vblnk,
  input  logic [1:0]             i_req,
  input  logic [11:0]            i_req_color0,
  input  logic [11:0]            i_req_color1,
  input  logic [BORDER_W-1:0]    i_req_border0,
  input  logic [BORDER_W-1:0]    i_req_border1,
  output logic [1:0]             o_ack,
  input  logic                   i_flash_start,
  input  logic [11:0]            i_flash_color,
  input  logic [FLASH_W-1:0]     i_flash_frames,
  output logic [11:0]            o_bg_color,
  output logic [BORDER_W-1:0]    o_border_width,
  output logic                   o_pending,
  output logic                   o_flash_active,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

  typedef enum logic {S_IDLE, S_PEND}  commit_state_t;
  typedef enum logic {S_NORM, S_FLASH} flash_state_t;

  localparam logic [BORDER_W-1:0] DEF_BORDER = BORDER_W'(DEFAULT_BORDER);

  commit_state_t r_cstate, w_cstate_nxt;
  flash_state_t  r_fstate, w_fstate_nxt;

  logic                   r_vblnk_q;
  logic                   r_rr, w_rr_nxt;
  logic [1:0]             r_ack, w_grant;
  logic [11:0]            r_shadow_color, r_active_color, r_bg_color;
  logic [BORDER_W-1:0]    r_shadow_border, r_border_width;
  logic [FLASH_W-1:0]     r_fcnt, w_fcnt_nxt;
  logic [11:0]            r_fcol, w_fcol_nxt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic                   w_frame_edge;
  logic                   w_commit;
  logic [11:0]            w_win_color, w_active_color_nxt, w_bg_nxt;
  logic [BORDER_W-1:0]    w_win_border;

  assign w_frame_edge = i_vblnk & ~r_vblnk_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_grant  = 2'b00;
    w_rr_nxt = r_rr;
    unique case (i_req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11: begin
        w_grant  = r_rr ? 2'b10 : 2'b01;
        w_rr_nxt = ~r_rr;
      end
      default: w_grant = 2'b00;
    endcase
  end

  assign w_win_color  = w_grant[1] ? i_req_color1  : i_req_color0;
  assign w_win_border = w_grant[1] ? i_req_border1 : i_req_border0;

  // A grant coinciding with the frame edge keeps the FSM pending: the old shadow
  // commits while the new value lands in the shadow.
  always_comb begin
    w_cstate_nxt = r_cstate;
    w_commit     = 1'b0;
    unique case (r_cstate)
      S_IDLE: if (|w_grant) w_cstate_nxt = S_PEND;
      S_PEND: begin
        w_commit = w_frame_edge;
        if (w_frame_edge && !(|w_grant)) w_cstate_nxt = S_IDLE;
      end
      default: w_cstate_nxt = S_IDLE;
    endcase
  end

  // A restart takes priority over the final countdown edge.
  always_comb begin
    w_fstate_nxt = r_fstate;
    w_fcnt_nxt   = r_fcnt;
    w_fcol_nxt   = r_fcol;
    if (i_flash_start && (i_flash_frames != '0)) begin
      w_fstate_nxt = S_FLASH;
      w_fcnt_nxt   = i_flash_frames;
      w_fcol_nxt   = i_flash_color;
    end else if ((r_fstate == S_FLASH) && w_frame_edge) begin
      if (r_fcnt == FLASH_W'(1)) w_fstate_nxt = S_NORM;
      w_fcnt_nxt = r_fcnt - FLASH_W'(1);
    end
  end

  assign w_active_color_nxt = w_commit ? r_shadow_color : r_active_color;
  assign w_bg_nxt = (w_fstate_nxt == S_FLASH) ? w_fcol_nxt : w_active_color_nxt;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the commit sees the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cstate <= S_IDLE;
      r_fstate <= S_NORM;
    end else begin
      r_cstate <= w_cstate_nxt;
      r_fstate <= w_fstate_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_q       <= 1'b1;
      r_rr            <= 1'b0;
      r_ack           <= 2'b00;
      r_shadow_color  <= DEFAULT_COLOR;
      r_shadow_border <= DEF_BORDER;
      r_active_color  <= DEFAULT_COLOR;
      r_border_width  <= DEF_BORDER;
      r_bg_color      <= DEFAULT_COLOR;
      r_fcnt          <= '0;
      r_fcol          <= '0;
      r_frame_cnt     <= '0;
    end else begin
      r_vblnk_q      <= i_vblnk;
      r_rr           <= w_rr_nxt;
      r_ack          <= w_grant;
      r_active_color <= w_active_color_nxt;
      r_bg_color     <= w_bg_nxt;
      r_fcnt         <= w_fcnt_nxt;
      r_fcol         <= w_fcol_nxt;
      if (|w_grant) begin
        r_shadow_color  <= w_win_color;
        r_shadow_border <= w_win_border;
      end
      if (w_commit)     r_border_width <= r_shadow_border;
      if (w_frame_edge) r_frame_cnt    <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign o_ack          = r_ack;
  assign o_bg_color     = r_bg_color;
  assign o_border_width = r_border_width;
  assign o_pending      = (r_cstate == S_PEND);
  assign o_flash_active = (r_fstate == S_FLASH);
  assign o_frame_cnt    = r_frame_cnt;

endmodule
